// File: rtl/flash_read_sequencer_if.sv
// rtl/flash_read_sequencer_if.sv - Wishbone slave bus bundle for the flash read sequencer
interface flash_read_sequencer_if;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output stb, cyc, we, sel, adr, dat_w, input ack, dat_r);
    modport slave  (input stb, cyc, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/flash_read_sequencer.sv
// rtl/flash_read_sequencer.sv - Wishbone-programmable sense timing sequencer for the 8x8 flash array
module flash_read_sequencer #(
    parameter logic [7:0] DEF_T_PRE = 8'd4,
    parameter logic [7:0] DEF_T_SEN = 8'd4,
    parameter logic [7:0] DEF_T_OUT = 8'd2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    flash_read_sequencer_if.slave   wbs,
    output logic                    sen1,
    output logic                    sen2,
    output logic [3:0]              out_en,
    input  logic [7:0]              flash_out,
    output logic                    irq
);
    typedef enum logic [1:0] {IDLE, PRE, SENSE, OUT} state_t;

    state_t          state;
    logic            ack_q;
    logic [31:0]     dat_q;
    logic            scan, irq_en;
    logic [1:0]      group;
    logic [7:0]      t_pre, t_sen, t_out;
    logic            start_p, abort_p;
    logic            done, err;
    logic [3:0][7:0] data;
    logic [1:0]      grp;
    logic            scan_l;
    logic [7:0]      len_pre, len_sen, len_out, cnt;
    logic            req, wr, done_clr, err_clr;
    logic [31:0]     rdata;

    function automatic logic [7:0] eff(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    assign req      = wbs.stb & wbs.cyc & ~ack_q;
    assign wr       = req & wbs.we;
    assign done_clr = wr && (wbs.adr[3:2] == 2'd2) && wbs.sel[0] && wbs.dat_w[1];
    assign err_clr  = wr && (wbs.adr[3:2] == 2'd2) && wbs.sel[0] && wbs.dat_w[2];
    assign wbs.ack   = ack_q;
    assign wbs.dat_r = dat_q;
    assign irq       = done & irq_en;

    wire unused_bits = ^{wbs.adr[31:4], wbs.adr[1:0], wbs.dat_w[31:24], wbs.sel[3]};

    always_comb begin
        rdata = 32'd0;
        case (wbs.adr[3:2])
            2'd0: rdata = {27'd0, irq_en, group, scan, 1'b0};
            2'd1: rdata = {8'd0, t_out, t_sen, t_pre};
            2'd2: rdata = {29'd0, err, done, (state != IDLE)};
            default: rdata = data;
        endcase
    end

    // Register file; START/ABORT become one-cycle pulses so the FSM reacts the cycle after ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            scan    <= 1'b0;
            group   <= 2'd0;
            irq_en  <= 1'b0;
            t_pre   <= DEF_T_PRE;
            t_sen   <= DEF_T_SEN;
            t_out   <= DEF_T_OUT;
            start_p <= 1'b0;
            abort_p <= 1'b0;
        end else begin
            ack_q   <= req;
            start_p <= 1'b0;
            abort_p <= 1'b0;
            if (req)
                dat_q <= rdata;
            if (wr) begin
                case (wbs.adr[3:2])
                    2'd0: if (wbs.sel[0]) begin
                        start_p <= wbs.dat_w[0];
                        scan    <= wbs.dat_w[1];
                        group   <= wbs.dat_w[3:2];
                        irq_en  <= wbs.dat_w[4];
                        abort_p <= wbs.dat_w[5];
                    end
                    2'd1: begin
                        if (wbs.sel[0]) t_pre <= wbs.dat_w[7:0];
                        if (wbs.sel[1]) t_sen <= wbs.dat_w[15:8];
                        if (wbs.sel[2]) t_out <= wbs.dat_w[23:16];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sense sequencer; cnt counts down the remaining cycles of the current phase.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state   <= IDLE;
            sen1    <= 1'b0;
            sen2    <= 1'b0;
            out_en  <= 4'd0;
            grp     <= 2'd0;
            scan_l  <= 1'b0;
            cnt     <= 8'd0;
            len_pre <= 8'd1;
            len_sen <= 8'd1;
            len_out <= 8'd1;
            done    <= 1'b0;
            err     <= 1'b0;
            data    <= '0;
        end else begin
            if (done_clr) done <= 1'b0;
            if (err_clr)  err  <= 1'b0;
            if (state == IDLE) begin
                if (start_p && !abort_p) begin
                    len_pre <= eff(t_pre);
                    len_sen <= eff(t_sen);
                    len_out <= eff(t_out);
                    scan_l  <= scan;
                    grp     <= scan ? 2'd0 : group;
                    cnt     <= eff(t_pre) - 8'd1;
                    sen1    <= 1'b1;
                    state   <= PRE;
                end
            end else if (abort_p) begin
                state  <= IDLE;
                sen1   <= 1'b0;
                sen2   <= 1'b0;
                out_en <= 4'd0;
            end else begin
                if (start_p) err <= 1'b1;
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    case (state)
                        PRE: begin
                            sen1  <= 1'b0;
                            sen2  <= 1'b1;
                            cnt   <= len_sen - 8'd1;
                            state <= SENSE;
                        end
                        SENSE: begin
                            out_en <= 4'b0001 << grp;
                            cnt    <= len_out - 8'd1;
                            state  <= OUT;
                        end
                        OUT: begin
                            data[grp] <= flash_out;
                            out_en    <= 4'd0;
                            sen2      <= 1'b0;
                            if (scan_l && grp != 2'd3) begin
                                grp   <= grp + 2'd1;
                                sen1  <= 1'b1;
                                cnt   <= len_pre - 8'd1;
                                state <= PRE;
                            end else begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_flash_read_sequencer.sv
// tb/tb_flash_read_sequencer.sv - directed table and sequence checks for flash_read_sequencer
module tb_flash_read_sequencer;
    logic       clk;
    logic       rst_n;
    logic       sen1, sen2, irq;
    logic [3:0] out_en;
    logic [7:0] flash_out;
    int         errors = 0;
    int         checks = 0;
    int         cyc_cnt = 0;

    flash_read_sequencer_if bus ();

    flash_read_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .wbs      (bus),
        .sen1     (sen1),
        .sen2     (sen2),
        .out_en   (out_en),
        .flash_out(flash_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [1:0]  adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];
    logic [7:0] fval[4];
    int c_pre, c_sen, c_out, done_k, first_pre, bad, ngrp;
    logic [15:0] gseq;
    logic [31:0] rd;
    int n0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] r);
        bit ok;
        @(negedge clk);
        bus.stb = 1'b1; bus.cyc = 1'b1; bus.we = w; bus.sel = s;
        bus.adr = {28'd0, a, 2'b00}; bus.dat_w = d;
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ack) begin ok = 1; break; end
        end
        r = bus.dat_r;
        bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
        if (!ok) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, 4'hF, d, dummy);
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(a, 1'b0, 4'hF, 32'd0, r);
        chk(name, r, exp);
    endtask

    // Follows the array strobes cycle by cycle, feeding fval[g] while group g is enabled.
    task automatic trace(input int start, input int maxk);
        int k, g, last_g;
        c_pre = 0; c_sen = 0; c_out = 0; done_k = -1; first_pre = -1; bad = 0;
        ngrp = 0; gseq = 16'd0; last_g = -1; k = 0;
        while (done_k < 0 && k < maxk) begin
            @(posedge clk); #1;
            k = cyc_cnt - start;
            if (sen1) begin c_pre++; if (first_pre < 0) first_pre = k; end
            if (sen2) c_sen++;
            if (sen1 && (sen2 || out_en != 4'd0)) bad++;
            if (out_en != 4'd0) begin
                c_out++;
                if (!sen2) bad++;
                case (out_en)
                    4'b0001: g = 0;
                    4'b0010: g = 1;
                    4'b0100: g = 2;
                    4'b1000: g = 3;
                    default: begin g = 0; bad++; end
                endcase
                if (g != last_g) begin
                    gseq = {gseq[11:0], 4'(g)};
                    ngrp++;
                    last_g = g;
                end
                flash_out = fval[g];
            end
            if (irq) done_k = k;
        end
    endtask

    initial begin
        bus.stb = 0; bus.cyc = 0; bus.we = 0; bus.sel = 0; bus.adr = 0; bus.dat_w = 0;
        flash_out = 8'h00;
        rst_n = 1'b0;
        vecs[0]  = '{2'd1, 1'b0, 4'hF, 32'h0,        32'h00020404};
        vecs[1]  = '{2'd2, 1'b0, 4'hF, 32'h0,        32'h00000000};
        vecs[2]  = '{2'd0, 1'b0, 4'hF, 32'h0,        32'h00000000};
        vecs[3]  = '{2'd3, 1'b0, 4'hF, 32'h0,        32'h00000000};
        vecs[4]  = '{2'd1, 1'b1, 4'h1, 32'h00AABBCC, 32'h0};
        vecs[5]  = '{2'd1, 1'b0, 4'hF, 32'h0,        32'h000204CC};
        vecs[6]  = '{2'd1, 1'b1, 4'h6, 32'hFF112233, 32'h0};
        vecs[7]  = '{2'd1, 1'b0, 4'hF, 32'h0,        32'h001122CC};
        vecs[8]  = '{2'd0, 1'b1, 4'hF, 32'h0000001E, 32'h0};
        vecs[9]  = '{2'd0, 1'b0, 4'hF, 32'h0,        32'h0000001E};
        vecs[10] = '{2'd0, 1'b1, 4'h0, 32'h0000003F, 32'h0};
        vecs[11] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'h0000001E};
        vecs[12] = '{2'd3, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[13] = '{2'd3, 1'b0, 4'hF, 32'h0,        32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {26'd0, sen1, sen2, out_en, irq, bus.ack}, 32'd0);
        chk("rst_dat", bus.dat_r, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            logic [31:0] r;
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wd, r);
            if (!vecs[i].we) chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        chk("idle_outputs", {27'd0, sen1, sen2, out_en} | {31'd0, irq}, 32'd0);

        // Single read, group 2
        fval = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        wr(2'd1, 32'h00030201);
        wr(2'd0, 32'h00000019);
        n0 = cyc_cnt;
        trace(n0, 40);
        chk("single_first_pre", first_pre, 1);
        chk("single_pre", c_pre, 1);
        chk("single_sen", c_sen, 5);
        chk("single_out", c_out, 3);
        chk("single_done_k", done_k, 7);
        chk("single_grp", {gseq, 16'(ngrp)}, {16'h0002, 16'd1});
        chk("single_bad", bad, 0);
        chk("single_irq", irq, 1'b1);
        rdchk("single_data", 2'd3, 32'h00A50000);
        rdchk("single_status", 2'd2, 32'h00000002);
        wr(2'd2, 32'h00000002);
        rdchk("single_w1c", 2'd2, 32'h0);
        chk("single_irq_clr", irq, 1'b0);

        // Scan of all four groups
        fval = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr(2'd0, 32'h00000013);
        n0 = cyc_cnt;
        trace(n0, 60);
        chk("scan_pre", c_pre, 4);
        chk("scan_sen", c_sen, 20);
        chk("scan_out", c_out, 12);
        chk("scan_done_k", done_k, 25);
        chk("scan_grp", {gseq, 16'(ngrp)}, {16'h0123, 16'd4});
        chk("scan_bad", bad, 0);
        rdchk("scan_data", 2'd3, 32'h44332211);
        wr(2'd2, 32'h00000002);

        // Zero timing, group 1
        fval = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
        wr(2'd1, 32'h00000000);
        wr(2'd0, 32'h00000015);
        n0 = cyc_cnt;
        trace(n0, 20);
        chk("zero_counts", {c_pre[7:0], c_sen[7:0], c_out[7:0]}, {8'd1, 8'd2, 8'd1});
        chk("zero_done_k", done_k, 4);
        rdchk("zero_data", 2'd3, 32'h44335A11);
        wr(2'd2, 32'h00000002);

        // START while busy
        fval = '{8'h77, 8'h77, 8'h77, 8'h77};
        wr(2'd1, 32'h00030201);
        wr(2'd0, 32'h00000011);
        n0 = cyc_cnt;
        wr(2'd0, 32'h00000011);
        trace(n0, 30);
        chk("busy_done_k", done_k, 7);
        rdchk("busy_status", 2'd2, 32'h00000006);
        begin
            logic [31:0] dummy;
            wb_xfer(2'd2, 1'b1, 4'hE, 32'h00000006, dummy);
        end
        rdchk("busy_sel_w1c", 2'd2, 32'h00000006);
        wr(2'd2, 32'h00000004);
        rdchk("busy_err_clr", 2'd2, 32'h00000002);
        wr(2'd2, 32'h00000002);
        rdchk("busy_data", 2'd3, 32'h44335A77);

        // ABORT during group 1 SENSE of a scan
        fval = '{8'h99, 8'h88, 8'h77, 8'h66};
        wr(2'd0, 32'h00000013);
        n0 = cyc_cnt;
        trace(n0, 7);
        wr(2'd0, 32'h00000032);
        chk("abort_active", {sen1, sen2}, 2'b01);
        @(posedge clk); #1;
        chk("abort_off", {26'd0, sen1, sen2, out_en, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_stay", {27'd0, sen1, sen2, out_en}, 32'd0);
        rdchk("abort_status", 2'd2, 32'h0);
        rdchk("abort_data", 2'd3, 32'h44335A99);

        // ABORT idle, START+ABORT together
        wr(2'd0, 32'h00000030);
        wr(2'd0, 32'h00000031);
        repeat (3) @(posedge clk);
        #1;
        chk("startabort_idle", {27'd0, sen1, sen2, out_en}, 32'd0);
        rdchk("startabort_status", 2'd2, 32'h0);

        // Asynchronous reset mid-OUT
        wr(2'd0, 32'h00000011);
        n0 = cyc_cnt;
        trace(n0, 5);
        chk("rst_mid_out", {28'd0, out_en}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", {26'd0, sen1, sen2, out_en, irq}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        rdchk("rst_timing", 2'd1, 32'h00020404);
        rdchk("rst_status", 2'd2, 32'h0);
        rdchk("rst_data", 2'd3, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
